// File: rtl/ge_p3_dbl.sv
// ge_p3_dbl: Ed25519 point doubling (p3 -> p2 -> p1p1) on 320-bit limb-form
// field elements. No arithmetic of its own: it sequences the shared
// multiplier, adder and subtractor through registered operand ports.
//   XX=X^2, YY=Y^2, B=2Z^2, A=X+Y, AA=A^2
//   r_y=YY+XX, r_z=YY-XX, r_x=AA-r_y, r_t=B-r_z
module ge_p3_dbl (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [319:0] p_x,
  input  logic [319:0] p_y,
  input  logic [319:0] p_z,
  input  logic [319:0] p_t,
  output logic [319:0] r_x,
  output logic [319:0] r_y,
  output logic [319:0] r_z,
  output logic [319:0] r_t,
  output logic         done,
  output logic         busy,
  output logic [319:0] mul_op_a,
  output logic [319:0] mul_op_b,
  output logic         mul_valid,
  input  logic [319:0] mul_res,
  input  logic         mul_done,
  output logic [319:0] add_op_a,
  output logic [319:0] add_op_b,
  input  logic [319:0] add_res,
  output logic [319:0] sub_op_a,
  output logic [319:0] sub_op_b,
  input  logic [319:0] sub_res
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_XX,
    S_W_YY,
    S_W_ZZ,
    S_W_AA,
    S_FIN1,
    S_FIN2,
    S_FIN3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  // Latched input coordinates still needed after acceptance (X is only
  // used on the accepting edge, where it goes straight to the operand ports).
  logic [319:0] r_y_in;
  logic [319:0] r_z_in;

  // Intermediate field values.
  logic [319:0] r_xx;
  logic [319:0] r_yy;
  logic [319:0] r_a;
  logic [319:0] r_b;
  logic [319:0] r_t0;
  logic [319:0] r_z3;

  // Result registers behind the r_* ports.
  logic [319:0] r_res_x;
  logic [319:0] r_res_y;
  logic [319:0] r_res_z;
  logic [319:0] r_res_t;

  // Operand registers for the shared units.
  logic [319:0] r_mul_a;
  logic [319:0] r_mul_b;
  logic [319:0] r_add_a;
  logic [319:0] r_add_b;
  logic [319:0] r_sub_a;
  logic [319:0] r_sub_b;

  logic         r_mul_valid;
  logic         r_done;

  // T is dropped by the p3 -> p2 step; the port exists only for hookup.
  logic         w_unused;
  assign w_unused = ^p_t;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each wait state advances only on the multiplier's
  // completion pulse; the FIN stages are fixed single cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (valid)    w_state_nxt = S_W_XX;
      S_W_XX: if (mul_done) w_state_nxt = S_W_YY;
      S_W_YY: if (mul_done) w_state_nxt = S_W_ZZ;
      S_W_ZZ: if (mul_done) w_state_nxt = S_W_AA;
      S_W_AA: if (mul_done) w_state_nxt = S_FIN1;
      S_FIN1:               w_state_nxt = S_FIN2;
      S_FIN2:               w_state_nxt = S_FIN3;
      S_FIN3:               w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operands and start pulse. Operands only change on the edge
  // that issues a new multiply, so they stay stable while one is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_valid <= 1'b0;
    end else begin
      r_mul_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (valid) begin
          r_mul_a     <= p_x;
          r_mul_b     <= p_x;
          r_mul_valid <= 1'b1;
        end
        S_W_XX: if (mul_done) begin
          r_mul_a     <= r_y_in;
          r_mul_b     <= r_y_in;
          r_mul_valid <= 1'b1;
        end
        S_W_YY: if (mul_done) begin
          r_mul_a     <= r_z_in;
          r_mul_b     <= r_z_in;
          r_mul_valid <= 1'b1;
        end
        S_W_ZZ: if (mul_done) begin
          r_mul_a     <= r_a;
          r_mul_b     <= r_a;
          r_mul_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Adder/subtractor operands. Their results are read one cycle after these
  // registers change: A=X+Y while XX is computed, ZZ+ZZ while AA is computed,
  // then the four output combinations in FIN1..FIN3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_add_a <= '0;
      r_add_b <= '0;
      r_sub_a <= '0;
      r_sub_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid) begin
          r_add_a <= p_x;
          r_add_b <= p_y;
        end
        S_W_ZZ: if (mul_done) begin
          r_add_a <= mul_res;
          r_add_b <= mul_res;
        end
        S_W_AA: if (mul_done) begin
          r_add_a <= r_yy;
          r_add_b <= r_xx;
          r_sub_a <= r_yy;
          r_sub_b <= r_xx;
        end
        S_FIN1: begin
          r_sub_a <= r_t0;
          r_sub_b <= add_res;
        end
        S_FIN2: begin
          r_sub_a <= r_b;
          r_sub_b <= r_z3;
        end
        default: ;
      endcase
    end
  end

  // Intermediate values captured from the shared units. B is refreshed every
  // W_AA cycle; the adder has held ZZ+ZZ since W_AA was entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y_in <= '0;
      r_z_in <= '0;
      r_xx   <= '0;
      r_yy   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_t0   <= '0;
      r_z3   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid) begin
          r_y_in <= p_y;
          r_z_in <= p_z;
        end
        S_W_XX: if (mul_done) begin
          r_xx <= mul_res;
          r_a  <= add_res;
        end
        S_W_YY: if (mul_done) begin
          r_yy <= mul_res;
        end
        S_W_AA: begin
          r_b <= add_res;
          if (mul_done) begin
            r_t0 <= mul_res;
          end
        end
        S_FIN1: begin
          r_z3 <= sub_res;
        end
        default: ;
      endcase
    end
  end

  // Result registers and completion pulse. Results hold until the next
  // operation's FIN stages overwrite them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_x <= '0;
      r_res_y <= '0;
      r_res_z <= '0;
      r_res_t <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_FIN1: r_res_y <= add_res;
        S_FIN2: r_res_x <= sub_res;
        S_FIN3: begin
          r_res_t <= sub_res;
          r_res_z <= r_z3;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // busy covers the whole operation including the done cycle, so it drops
  // together with done unless a new request was accepted on that edge.
  assign busy      = (r_state != S_IDLE) | r_done;
  assign done      = r_done;
  assign r_x       = r_res_x;
  assign r_y       = r_res_y;
  assign r_z       = r_res_z;
  assign r_t       = r_res_t;
  assign mul_op_a  = r_mul_a;
  assign mul_op_b  = r_mul_b;
  assign mul_valid = r_mul_valid;
  assign add_op_a  = r_add_a;
  assign add_op_b  = r_add_b;
  assign sub_op_a  = r_sub_a;
  assign sub_op_b  = r_sub_b;

endmodule

// File: tb/tb_ge_p3_dbl.sv
// Bench for ge_p3_dbl: models the shared multiplier (variable latency),
// adder and subtractor as arithmetic mod 2^255-19, keeps a scoreboard of
// expected p1p1 results, and walks a directed sequence of operations.
module tb_ge_p3_dbl;

  localparam logic [319:0] P = (320'd1 << 255) - 320'd19;

  typedef struct {
    logic [319:0] x;
    logic [319:0] y;
    logic [319:0] z;
    logic [319:0] t;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic [319:0] p_x = '0;
  logic [319:0] p_y = '0;
  logic [319:0] p_z = '0;
  logic [319:0] p_t = '0;
  logic [319:0] r_x, r_y, r_z, r_t;
  logic         done, busy;
  logic [319:0] mul_op_a, mul_op_b;
  logic         mul_valid;
  logic [319:0] mul_res = '0;
  logic         mul_done = 1'b0;
  logic [319:0] add_op_a, add_op_b, add_res;
  logic [319:0] sub_op_a, sub_op_b, sub_res;

  int total = 0;
  int bad = 0;

  res_t sb[$];

  int lat_fixed = 1;
  int lat_sum = 0;
  int mv_count = 0;
  int m_cnt = 0;
  int m_l = 0;
  int last_cyc = 0;
  bit stray_req = 1'b0;
  logic [319:0] m_a = '0;
  logic [319:0] m_b = '0;

  ge_p3_dbl dut (
    .clk(clk), .rst(rst), .valid(valid),
    .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
    .r_x(r_x), .r_y(r_y), .r_z(r_z), .r_t(r_t),
    .done(done), .busy(busy),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_valid(mul_valid),
    .mul_res(mul_res), .mul_done(mul_done),
    .add_op_a(add_op_a), .add_op_b(add_op_b), .add_res(add_res),
    .sub_op_a(sub_op_a), .sub_op_b(sub_op_b), .sub_res(sub_res)
  );

  always #5 clk = ~clk;

  function automatic logic [319:0] fadd(input logic [319:0] a, input logic [319:0] b);
    logic [639:0] t;
    t = {320'd0, a} + {320'd0, b};
    t = t % {320'd0, P};
    return t[319:0];
  endfunction

  function automatic logic [319:0] fsub(input logic [319:0] a, input logic [319:0] b);
    logic [639:0] t;
    t = {320'd0, a % P} + {320'd0, P} - {320'd0, b % P};
    t = t % {320'd0, P};
    return t[319:0];
  endfunction

  function automatic logic [319:0] fmul(input logic [319:0] a, input logic [319:0] b);
    logic [639:0] t;
    t = {320'd0, a} * {320'd0, b};
    t = t % {320'd0, P};
    return t[319:0];
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v = {v[287:0], $urandom()};
    return v;
  endfunction

  function automatic logic [319:0] rnd_fe();
    return rnd320() % P;
  endfunction

  function automatic res_t model_dbl(input logic [319:0] x, input logic [319:0] y,
                                     input logic [319:0] z);
    res_t r;
    logic [319:0] xx, yy, b, aa;
    xx  = fmul(x, x);
    yy  = fmul(y, y);
    b   = fadd(fmul(z, z), fmul(z, z));
    aa  = fmul(fadd(x, y), fadd(x, y));
    r.y = fadd(yy, xx);
    r.z = fsub(yy, xx);
    r.x = fsub(aa, r.y);
    r.t = fsub(b, r.z);
    return r;
  endfunction

  assign add_res = fadd(add_op_a, add_op_b);
  assign sub_res = fsub(sub_op_a, sub_op_b);

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shared multiplier model: latches operands at the mul_valid cycle, answers
  // L cycles later, and checks the operands stay put while it is busy.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt    = 0;
      mul_done = 1'b0;
    end else begin
      mul_done = 1'b0;
      mul_res  = rnd320();
      if (stray_req) begin
        mul_done  = 1'b1;
        stray_req = 1'b0;
      end
      if (m_cnt > 0) begin
        chk("mul_ops_stable", (mul_op_a ^ m_a) | (mul_op_b ^ m_b), '0);
        m_cnt--;
        if (m_cnt == 0) begin
          mul_done = 1'b1;
          mul_res  = fmul(m_a, m_b);
        end
      end
      if (mul_valid === 1'b1) begin
        chk("mul_valid_overlap", 320'(m_cnt), '0);
        mv_count++;
        m_a = mul_op_a;
        m_b = mul_op_b;
        m_l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(40, 1));
        lat_sum += m_l;
        m_cnt = m_l;
      end
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_r_x"}, r_x, '0);
    chk({pfx, "_r_y"}, r_y, '0);
    chk({pfx, "_r_z"}, r_z, '0);
    chk({pfx, "_r_t"}, r_t, '0);
    chk({pfx, "_done"}, 320'(done), '0);
    chk({pfx, "_busy"}, 320'(busy), '0);
    chk({pfx, "_mul_valid"}, 320'(mul_valid), '0);
    chk({pfx, "_mul_ops"}, mul_op_a | mul_op_b, '0);
    chk({pfx, "_add_ops"}, add_op_a | add_op_b, '0);
    chk({pfx, "_sub_ops"}, sub_op_a | sub_op_b, '0);
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    chk({tag, "_sb_nonempty"}, 320'(sb.size() > 0), 320'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_r_x"}, r_x, e.x);
      chk({tag, "_r_y"}, r_y, e.y);
      chk({tag, "_r_z"}, r_z, e.z);
      chk({tag, "_r_t"}, r_t, e.t);
    end
  endtask

  // One full operation from an idle DUT; lat=0 selects random L per multiply.
  task automatic run_op(input string tag, input logic [319:0] x, input logic [319:0] y,
                        input logic [319:0] z, input int lat, input res_t exp);
    int cyc;
    @(negedge clk);
    lat_fixed = lat;
    mv_count  = 0;
    lat_sum   = 0;
    p_x = x; p_y = y; p_z = z; p_t = rnd320();
    valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    p_x = rnd320(); p_y = rnd320(); p_z = rnd320();
    chk({tag, "_busy_c0"}, 320'(busy), 320'(1));
    cyc = -1;
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    last_cyc = cyc;
    chk({tag, "_latency"}, 320'(cyc), 320'(lat_sum + 7));
    chk({tag, "_mul_pulses"}, 320'(mv_count), 320'(4));
    chk({tag, "_busy_done"}, 320'(busy), 320'(1));
    pop_check(tag);
    @(negedge clk);
    chk({tag, "_done_low"}, 320'(done), '0);
    chk({tag, "_busy_low"}, 320'(busy), '0);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [319:0] bx, by, qx, qy, qz;
    int cyc;
    int seen;
    res_t e_id, e_small;
    e_id    = '{320'd0, 320'd1, 320'd1, 320'd1};
    e_small = '{320'd8, 320'd8, 320'd0, 320'd8};
    bx = 320'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
    by = 320'h6666666666666666666666666666666666666666666666666666666666666658;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    run_op("identity", 320'd0, 320'd1, 320'd1, 1, e_id);
    chk("identity_cycle11", 320'(last_cyc), 320'(11));

    run_op("small", 320'h2, 320'h2, 320'h2, 37, e_small);
    chk("small_cycle155", 320'(last_cyc), 320'(155));

    run_op("basepoint", bx, by, 320'd1, 0, model_dbl(bx, by, 320'd1));

    for (int i = 0; i < 3; i++) begin
      qx = rnd_fe(); qy = rnd_fe(); qz = rnd_fe();
      run_op("random", qx, qy, qz, 0, model_dbl(qx, qy, qz));
    end

    // Back-to-back with valid held high; inputs scrambled while busy.
    @(negedge clk);
    lat_fixed = 3; mv_count = 0; lat_sum = 0;
    qx = rnd_fe(); qy = rnd_fe(); qz = rnd_fe();
    p_x = qx; p_y = qy; p_z = qz;
    valid = 1'b1;
    sb.push_back(model_dbl(qx, qy, qz));
    @(posedge clk);
    cyc = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
      p_x = rnd320(); p_y = rnd320(); p_z = rnd320();
    end
    chk("b2b1_latency", 320'(cyc), 320'(lat_sum + 7));
    chk("b2b1_mul_pulses", 320'(mv_count), 320'(4));
    pop_check("b2b1");
    qx = rnd_fe(); qy = rnd_fe(); qz = rnd_fe();
    p_x = qx; p_y = qy; p_z = qz;
    sb.push_back(model_dbl(qx, qy, qz));
    mv_count = 0; lat_sum = 0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b2_start_mul_valid", 320'(mul_valid), 320'(1));
    chk("b2b2_start_busy", 320'(busy), 320'(1));
    cyc = -1;
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        valid = 1'b0;
        break;
      end
      p_x = rnd320(); p_y = rnd320(); p_z = rnd320();
    end
    valid = 1'b0;
    chk("b2b2_latency", 320'(cyc), 320'(lat_sum + 7));
    chk("b2b2_mul_pulses", 320'(mv_count), 320'(4));
    pop_check("b2b2");
    @(negedge clk);
    chk("b2b_done_low", 320'(done), '0);
    chk("b2b_busy_low", 320'(busy), '0);

    // Reset during W_YY, then a stale mul_done after release.
    @(negedge clk);
    lat_fixed = 4; mv_count = 0; lat_sum = 0;
    p_x = rnd_fe(); p_y = rnd_fe(); p_z = rnd_fe();
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (mv_count >= 2) break;
      @(negedge clk);
    end
    chk("midop_in_wyy", 320'(mv_count), 320'(2));
    #1;
    rst = 1'b0;
    #1;
    chk_zero("midop_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stray_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1 || mul_valid === 1'b1) seen++;
    end
    chk("stray_ignored", 320'(seen), '0);
    chk_zero("after_stray");

    run_op("identity2", 320'd0, 320'd1, 320'd1, 1, e_id);
    chk("identity2_cycle11", 320'(last_cyc), 320'(11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
